// File: rtl/mem_arbiter.sv
// Shared backing-memory arbiter: serialises I-cache line reads and D-cache line reads/writes
// onto one single-word synchronous memory port, D-cache always ahead of I-cache.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned WORDS  = 4
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      i_req,
  input  logic [ADDR_W-1:0]         i_addr,
  output logic                      i_done,
  output logic [WORDS*DATA_W-1:0]   i_line,
  input  logic [1:0]                d_req,
  input  logic [ADDR_W-1:0]         d_addr,
  input  logic [WORDS*DATA_W-1:0]   d_wline,
  output logic                      d_done,
  output logic [WORDS*DATA_W-1:0]   d_rline,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int unsigned OFF_W  = $clog2(WORDS);
  localparam int unsigned BEAT_W = OFF_W + 1;
  localparam int unsigned LINE_W = WORDS * DATA_W;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);
  localparam logic [BEAT_W-1:0] CAP_END   = BEAT_W'(WORDS);
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(WORDS - 1);

  localparam logic [1:0] REQ_READ  = 2'd1;
  localparam logic [1:0] REQ_WRITE = 2'd2;

  typedef enum logic [2:0] {
    READY,
    I_READING,
    D_WRITING,
    D_READY,
    D_READING
  } MemState;

  MemState             r_state, w_state_next;
  logic [BEAT_W-1:0]   r_beat, w_beat_next;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   r_mem_addr_hold;
  logic [DATA_W-1:0]   r_mem_wdata_hold;
  logic [LINE_W-1:0]   r_wline;
  logic [LINE_W-1:0]   r_buf, w_buf_next;
  logic [LINE_W-1:0]   r_i_line, r_d_rline;
  logic                r_i_done, r_d_done;
  logic                w_i_done_next, w_d_done_next;
  logic                w_latch_i, w_latch_d;
  logic                w_mem_en, w_mem_we;
  logic                w_i_rd, w_d_rd, w_d_wr;
  logic                w_capture;
  logic [OFF_W-1:0]    w_cap_idx, w_word_idx;

  // A requester whose done is high this cycle is masked so a held request is not re-accepted.
  assign w_i_rd = i_req && !r_i_done;
  assign w_d_rd = (d_req == REQ_READ) && !r_d_done;
  assign w_d_wr = (d_req == REQ_WRITE) && !r_d_done;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= READY;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_next;
      r_beat  <= w_beat_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_beat_next   = r_beat;
    w_i_done_next = 1'b0;
    w_d_done_next = 1'b0;
    w_latch_i     = 1'b0;
    w_latch_d     = 1'b0;
    w_mem_en      = 1'b0;
    w_mem_we      = 1'b0;
    case (r_state)
      READY: begin
        w_beat_next = '0;
        if (w_d_wr) begin
          w_state_next = D_WRITING;
          w_latch_d    = 1'b1;
        end else if (w_d_rd) begin
          w_state_next = D_READING;
          w_latch_d    = 1'b1;
        end else if (w_i_rd) begin
          w_state_next = I_READING;
          w_latch_i    = 1'b1;
        end
      end
      I_READING, D_READING: begin
        // Beats 0..WORDS-1 issue reads; the extra step captures the final word.
        if (r_beat == CAP_END) begin
          w_state_next = READY;
          w_beat_next  = '0;
          if (r_state == I_READING) w_i_done_next = 1'b1;
          else                      w_d_done_next = 1'b1;
        end else begin
          w_mem_en    = 1'b1;
          w_beat_next = r_beat + 1'b1;
        end
      end
      D_WRITING: begin
        w_mem_en = 1'b1;
        w_mem_we = 1'b1;
        if (r_beat == LAST_BEAT) begin
          w_state_next  = D_READY;
          w_beat_next   = '0;
          w_d_done_next = 1'b1;
        end else begin
          w_beat_next = r_beat + 1'b1;
        end
      end
      D_READY: begin
        w_beat_next = '0;
        if (w_d_wr) begin
          w_state_next = D_WRITING;
          w_latch_d    = 1'b1;
        end else if (w_d_rd) begin
          w_state_next = D_READING;
          w_latch_d    = 1'b1;
        end else if (!r_d_done) begin
          w_state_next = READY;
        end
      end
      default: begin
        w_state_next = READY;
        w_beat_next  = '0;
      end
    endcase
  end

  assign w_capture  = ((r_state == I_READING) || (r_state == D_READING)) && (r_beat != '0);
  assign w_cap_idx  = OFF_W'(r_beat - 1'b1);
  assign w_word_idx = r_beat[OFF_W-1:0];

  always_comb begin
    w_buf_next = r_buf;
    if (w_capture) w_buf_next[w_cap_idx*DATA_W +: DATA_W] = mem_rdata;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_base           <= '0;
      r_wline          <= '0;
      r_buf            <= '0;
      r_i_line         <= '0;
      r_d_rline        <= '0;
      r_i_done         <= 1'b0;
      r_d_done         <= 1'b0;
      r_mem_addr_hold  <= '0;
      r_mem_wdata_hold <= '0;
    end else begin
      r_buf    <= w_buf_next;
      r_i_done <= w_i_done_next;
      r_d_done <= w_d_done_next;
      if (w_latch_i) r_base <= i_addr & BASE_MASK;
      if (w_latch_d) begin
        r_base  <= d_addr & BASE_MASK;
        r_wline <= d_wline;
      end
      if (w_i_done_next) r_i_line <= w_buf_next;
      if (w_d_done_next && (r_state == D_READING)) r_d_rline <= w_buf_next;
      if (w_mem_en) begin
        r_mem_addr_hold <= mem_addr;
        if (w_mem_we) r_mem_wdata_hold <= mem_wdata;
      end
    end
  end

  assign mem_en    = w_mem_en;
  assign mem_we    = w_mem_we;
  assign mem_addr  = w_mem_en ? (r_base + ADDR_W'(r_beat)) : r_mem_addr_hold;
  assign mem_wdata = w_mem_we ? r_wline[w_word_idx*DATA_W +: DATA_W] : r_mem_wdata_hold;
  assign i_done    = r_i_done;
  assign d_done    = r_d_done;
  assign i_line    = r_i_line;
  assign d_rline   = r_d_rline;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table-driven I refill, hand-written corner sequences, and random
// concurrent I/D traffic checked against a line-level shadow memory.
module tb_mem_arbiter;

  logic        clk;
  logic        n_rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_done;
  logic [63:0] i_line;
  logic [1:0]  d_req;
  logic [15:0] d_addr;
  logic [63:0] d_wline;
  logic        d_done;
  logic [63:0] d_rline;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WORDS(4)) u_dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_done    (i_done),
    .i_line    (i_line),
    .d_req     (d_req),
    .d_addr    (d_addr),
    .d_wline   (d_wline),
    .d_done    (d_done),
    .d_rline   (d_rline),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous single-word memory, read data valid the cycle after the access.
  logic [15:0] mem [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i);
    mem_rdata = '0;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } acc_t;
  acc_t acc_q[$];
  int   i_q[$];
  int   d_q[$];

  always @(negedge clk) begin
    if (mem_en) acc_q.push_back('{cyc, mem_we, mem_addr, mem_wdata});
    if (i_done) i_q.push_back(cyc);
    if (d_done) d_q.push_back(cyc);
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_logs();
    acc_q.delete();
    i_q.delete();
    d_q.delete();
  endtask

  // The last WORDS accesses must be base..base+3 on consecutive cycles ending lat cycles
  // before the done pulse, with write data taken word by word from the line.
  task automatic check_beats(input string name, input logic [15:0] base, input bit we,
                             input logic [63:0] line, input int done_c, input int lat);
    int   ok;
    int   n;
    acc_t a;
    ok = 0;
    n  = acc_q.size();
    if (n >= 4) begin
      for (int k = 0; k < 4; k++) begin
        a = acc_q[n-4+k];
        if (a.addr == 16'(base + k) && a.we == we && a.c == done_c - lat - 3 + k &&
            (!we || a.wdata == line[k*16 +: 16])) ok++;
      end
    end
    check(name, 64'(ok), 64'd4);
  endtask

  logic [15:0] refmem [0:255];

  function automatic logic [63:0] ref_line(input logic [15:0] base);
    logic [63:0] l;
    for (int k = 0; k < 4; k++) l[k*16 +: 16] = refmem[8'(base + 16'(k))];
    return l;
  endfunction

  task automatic i_agent(input int n);
    logic [15:0] base;
    int          t;
    bit          got;
    for (int j = 0; j < n; j++) begin
      repeat ($urandom_range(0, 4)) step();
      i_addr = 16'($urandom_range(0, 255));
      base   = i_addr & 16'hFFFC;
      i_req  = 1'b1;
      got    = 1'b0;
      for (t = 0; t < 200 && !got; t++) begin
        step();
        got = i_done;
      end
      i_req = 1'b0;
      if (!got) begin
        check("rnd_i_timeout", 64'd0, 64'd1);
        break;
      end
      check("rnd_i_line", i_line, ref_line(base));
      check_beats("rnd_i_beats", base, 1'b0, 64'd0, cyc, 2);
    end
  endtask

  task automatic d_agent(input int n);
    logic [15:0] base;
    logic [63:0] wl;
    bit          wr;
    bit          got;
    for (int j = 0; j < n; j++) begin
      repeat ($urandom_range(0, 4)) begin
        d_req = ($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0;
        step();
      end
      wr      = ($urandom_range(0, 1) == 1);
      wl      = {$urandom, $urandom};
      d_addr  = 16'($urandom_range(0, 255));
      d_wline = wl;
      base    = d_addr & 16'hFFFC;
      d_req   = wr ? 2'd2 : 2'd1;
      got     = 1'b0;
      for (int t = 0; t < 200 && !got; t++) begin
        step();
        got = d_done;
      end
      d_req = 2'd0;
      if (!got) begin
        check("rnd_d_timeout", 64'd0, 64'd1);
        break;
      end
      if (wr) begin
        check_beats("rnd_d_wbeats", base, 1'b1, wl, cyc, 1);
        for (int k = 0; k < 4; k++) refmem[8'(base + 16'(k))] = wl[k*16 +: 16];
      end else begin
        check("rnd_d_rline", d_rline, ref_line(base));
        check_beats("rnd_d_rbeats", base, 1'b0, 64'd0, cyc, 2);
      end
    end
  endtask

  task automatic held_seq(input string tag, input int hold_after, input int exp_n,
                          input int exp_last);
    int t0;
    int dn;
    clear_logs();
    d_req  = 2'd1;
    d_addr = 16'h0066;
    t0     = cyc;
    dn     = -1;
    for (int k = 0; k < 30; k++) begin
      step();
      if (d_done && dn < 0) dn = cyc;
      if (dn >= 0 && cyc == dn + hold_after) d_req = 2'd0;
    end
    d_req = 2'd0;
    check({tag, "_n_done"}, 64'(d_q.size()), 64'(exp_n));
    check({tag, "_first_t"}, (d_q.size() > 0) ? 64'(d_q[0] - t0) : 64'hFFFF, 64'd6);
    check({tag, "_last_t"}, (d_q.size() > 0) ? 64'(d_q[d_q.size()-1] - t0) : 64'hFFFF,
          64'(exp_last));
    check({tag, "_n_acc"}, 64'(acc_q.size()), 64'(4 * exp_n));
    check({tag, "_rline"}, d_rline, 64'h0067_0066_0065_0064);
  endtask

  typedef struct {
    bit          req;
    logic [15:0] addr;
    bit          en;
    bit          we;
    logic [15:0] maddr;
    bit          done;
  } vec_t;
  vec_t tbl[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int t0;
    int ph;
    int nacc;
    int wok;

    // T0..T8 of an I refill from 0x0013 right after reset.
    tbl[0] = '{1'b1, 16'h0013, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[1] = '{1'b1, 16'h0013, 1'b1, 1'b0, 16'h0010, 1'b0};
    tbl[2] = '{1'b1, 16'h0013, 1'b1, 1'b0, 16'h0011, 1'b0};
    tbl[3] = '{1'b1, 16'h0013, 1'b1, 1'b0, 16'h0012, 1'b0};
    tbl[4] = '{1'b1, 16'h0013, 1'b1, 1'b0, 16'h0013, 1'b0};
    tbl[5] = '{1'b1, 16'h0013, 1'b0, 1'b0, 16'h0013, 1'b0};
    tbl[6] = '{1'b0, 16'h0013, 1'b0, 1'b0, 16'h0013, 1'b1};
    tbl[7] = '{1'b0, 16'h0013, 1'b0, 1'b0, 16'h0013, 1'b0};
    tbl[8] = '{1'b0, 16'h0013, 1'b0, 1'b0, 16'h0013, 1'b0};

    n_rst   = 1'b1;
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 2'd0;
    d_addr  = '0;
    d_wline = '0;
    #1 n_rst = 1'b0;
    #2;
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_i_done", 64'(i_done), 64'd0);
    check("rst_d_done", 64'(d_done), 64'd0);
    check("rst_i_line", i_line, 64'd0);
    check("rst_d_rline", d_rline, 64'd0);
    repeat (3) step();
    n_rst = 1'b1;
    clear_logs();
    repeat (5) step();
    check("idle_no_acc", 64'(acc_q.size()), 64'd0);

    for (int k = 0; k < 9; k++) begin
      check($sformatf("iref_en[%0d]", k), 64'(mem_en), 64'(tbl[k].en));
      check($sformatf("iref_we[%0d]", k), 64'(mem_we), 64'(tbl[k].we));
      check($sformatf("iref_addr[%0d]", k), 64'(mem_addr), 64'(tbl[k].maddr));
      check($sformatf("iref_done[%0d]", k), 64'(i_done), 64'(tbl[k].done));
      i_req  = tbl[k].req;
      i_addr = tbl[k].addr;
      step();
    end
    check("iref_line", i_line, 64'h0013_0012_0011_0010);

    // Simultaneous requests: D first, I accepted in D's done cycle.
    clear_logs();
    i_req  = 1'b1;
    i_addr = 16'h0021;
    d_req  = 2'd1;
    d_addr = 16'h0032;
    t0     = cyc;
    for (int k = 0; k < 20; k++) begin
      step();
      if (d_done) d_req = 2'd0;
      if (i_done) i_req = 1'b0;
    end
    check("sim_d_t", (d_q.size() > 0) ? 64'(d_q[0] - t0) : 64'hFFFF, 64'd6);
    check("sim_i_t", (i_q.size() > 0) ? 64'(i_q[0] - t0) : 64'hFFFF, 64'd12);
    check("sim_d_line", d_rline, 64'h0033_0032_0031_0030);
    check("sim_i_line", i_line, 64'h0023_0022_0021_0020);

    // Write-back, then refill from D_READY ahead of a waiting I request.
    clear_logs();
    d_req   = 2'd2;
    d_addr  = 16'h0040;
    d_wline = 64'hDDDD_CCCC_BBBB_AAAA;
    i_req   = 1'b1;
    i_addr  = 16'h0050;
    t0      = cyc;
    ph      = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (d_done) begin
        if (ph == 0) begin
          d_req  = 2'd1;
          d_addr = 16'h0080;
          ph     = 1;
        end else begin
          d_req = 2'd0;
        end
      end
      if (i_done) i_req = 1'b0;
    end
    wok = 0;
    if (acc_q.size() >= 5) begin
      for (int k = 0; k < 4; k++) begin
        if (acc_q[k].we && acc_q[k].addr == 16'(16'h0040 + k) && acc_q[k].c == t0 + 1 + k &&
            acc_q[k].wdata == d_wline[k*16 +: 16]) wok++;
      end
      check("wb_refill_addr", 64'(acc_q[4].addr), 64'h0080);
      check("wb_refill_t", 64'(acc_q[4].c - t0), 64'd7);
    end else begin
      check("wb_acc_count", 64'(acc_q.size()), 64'd12);
    end
    check("wb_write_beats", 64'(wok), 64'd4);
    check("wb_d_done_t0", (d_q.size() > 0) ? 64'(d_q[0] - t0) : 64'hFFFF, 64'd5);
    check("wb_d_done_t1", (d_q.size() > 1) ? 64'(d_q[1] - t0) : 64'hFFFF, 64'd12);
    check("wb_i_done_t", (i_q.size() > 0) ? 64'(i_q[0] - t0) : 64'hFFFF, 64'd18);
    check("wb_mem", {mem[16'h0043], mem[16'h0042], mem[16'h0041], mem[16'h0040]},
          64'hDDDD_CCCC_BBBB_AAAA);
    check("wb_d_rline", d_rline, 64'h0083_0082_0081_0080);
    check("wb_i_line", i_line, 64'h0053_0052_0051_0050);

    // d_req = 3 is NONE.
    clear_logs();
    d_req = 2'd3;
    repeat (10) step();
    d_req = 2'd0;
    check("req3_no_acc", 64'(acc_q.size()), 64'd0);
    check("req3_no_done", 64'(d_q.size()), 64'd0);

    held_seq("held_a", 1, 1, 6);
    held_seq("held_b", 2, 2, 13);

    // Reset in the middle of a D read at beat 2.
    clear_logs();
    d_req  = 2'd1;
    d_addr = 16'h0070;
    repeat (3) step();
    check("mid_en", 64'(mem_en), 64'd1);
    check("mid_addr", 64'(mem_addr), 64'h0072);
    n_rst = 1'b0;
    d_req = 2'd0;
    #1;
    check("arst_mem_en", 64'(mem_en), 64'd0);
    check("arst_mem_addr", 64'(mem_addr), 64'd0);
    check("arst_i_line", i_line, 64'd0);
    check("arst_d_rline", d_rline, 64'd0);
    check("arst_d_done", 64'(d_done), 64'd0);
    repeat (2) step();
    n_rst = 1'b1;
    clear_logs();
    repeat (10) step();
    check("post_rst_no_done", 64'(d_q.size() + i_q.size()), 64'd0);
    check("post_rst_no_acc", 64'(acc_q.size()), 64'd0);

    // Random concurrent traffic against the shadow memory.
    for (int i = 0; i < 256; i++) refmem[i] = mem[i];
    clear_logs();
    fork
      i_agent(25);
      d_agent(25);
    join
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
